// File: rtl/scan_mux_if.sv
// ---------------------------------------------------------------------------
// scan_mux_if
//
// Bus bundle between a scan_mux and whatever drives and consumes it.
//
// Parameters
//   WIDTH : data width of one channel in bits
//   NCH   : number of source channels
//   SELW  : channel index width, derived from NCH (minimum 1 bit)
//
// Signals
//   din   : packed channel data, channel k at bits [k*WIDTH +: WIDTH]
//   sel   : manual channel select
//   auto  : 1 = round-robin scan, 0 = manual select
//   hold  : 1 = freeze the mux state
//   dout  : registered data of the current channel
//   ch    : registered current channel index
//   sw    : one-cycle strobe, high in the cycle after ch changed
//
// Modports
//   master : the source/controller side (drives din, sel, auto, hold)
//   slave  : the scan_mux side (drives dout, ch, sw)
// ---------------------------------------------------------------------------
interface scan_mux_if #(
  parameter int WIDTH = 4,
  parameter int NCH   = 4
);

  // Index width is never zero so a single-channel build still has a port.
  localparam int SELW = (NCH > 1) ? $clog2(NCH) : 1;

  logic [NCH*WIDTH-1:0] din;
  logic [SELW-1:0]      sel;
  logic                 auto;
  logic                 hold;
  logic [WIDTH-1:0]     dout;
  logic [SELW-1:0]      ch;
  logic                 sw;

  modport master (
    output din,
    output sel,
    output auto,
    output hold,
    input  dout,
    input  ch,
    input  sw
  );

  modport slave (
    input  din,
    input  sel,
    input  auto,
    input  hold,
    output dout,
    output ch,
    output sw
  );

endinterface

// File: rtl/scan_mux.sv
// ---------------------------------------------------------------------------
// scan_mux
//
// N-channel, WIDTH-bit registered multiplexer used to time-share a single
// display/datapath between several source buses. In manual mode the channel
// comes from sel; in auto mode the mux scans the channels round-robin,
// dwelling DWELL cycles on each one. Data, channel index and the
// channel-switch strobe all come straight from registers.
//
// Parameters
//   WIDTH : data width per channel in bits
//   NCH   : number of input channels (>= 1)
//   DWELL : cycles spent on each channel in auto mode (>= 1)
//   The bus interface must be built with the same WIDTH and NCH.
//
// Ports
//   clk : clock, all state updates on the rising edge
//   rst : synchronous active-high reset, overrides everything else
//   bus : scan_mux_if slave modport
//         din/sel/auto/hold in, dout/ch/sw out
// ---------------------------------------------------------------------------
module scan_mux #(
  parameter int WIDTH = 4,
  parameter int NCH   = 4,
  parameter int DWELL = 4
) (
  input logic       clk,
  input logic       rst,
  scan_mux_if.slave bus
);

  // Channel index and dwell counter widths; both are kept at least one bit
  // wide so the degenerate NCH=1 / DWELL=1 builds still elaborate cleanly.
  localparam int SELW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int CNTW = (DWELL > 1) ? $clog2(DWELL) : 1;

  localparam logic [SELW-1:0] CH_LAST  = SELW'(NCH - 1);
  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(DWELL - 1);

  // NCH is compared against sel one bit wider so that the full range of sel
  // codes can be tested even when NCH is a power of two.
  localparam logic [SELW:0]   NCH_EXT  = (SELW + 1)'(NCH);

  // What the mux does on the coming edge, in priority order.
  typedef enum logic [1:0] {
    MODE_RESET,
    MODE_HOLD,
    MODE_MANUAL,
    MODE_AUTO
  } mode_t;

  mode_t              mode;

  logic [SELW-1:0]    ch_q;
  logic [CNTW-1:0]    cnt_q;
  logic [WIDTH-1:0]   dout_q;
  logic               sw_q;

  logic [SELW-1:0]    ch_d;
  logic [CNTW-1:0]    cnt_d;
  logic [WIDTH-1:0]   dout_d;
  logic               sw_d;

  logic [SELW-1:0]    nch;
  logic [CNTW-1:0]    cnt_next;
  logic               sel_ok;
  logic [WIDTH-1:0]   din_pick;

  // Decode the control inputs into a single mode. Reset beats hold, and
  // hold beats both the manual and the auto path.
  always_comb begin
    mode = MODE_MANUAL;
    if (rst) begin
      mode = MODE_RESET;
    end else if (bus.hold) begin
      mode = MODE_HOLD;
    end else if (bus.auto) begin
      mode = MODE_AUTO;
    end
  end

  // Work out which channel the mux should show after this edge and what the
  // dwell counter becomes. An out-of-range manual select leaves the current
  // channel in place instead of pointing at a channel that does not exist.
  // Leaving manual mode always starts auto with a cleared counter, so the
  // first dwell after a mode change is a full DWELL cycles.
  always_comb begin
    nch      = ch_q;
    cnt_next = '0;
    sel_ok   = ({1'b0, bus.sel} < NCH_EXT);
    case (mode)
      MODE_MANUAL: begin
        if (sel_ok) begin
          nch = bus.sel;
        end
        cnt_next = '0;
      end
      MODE_AUTO: begin
        if (cnt_q == CNT_LAST) begin
          nch      = (ch_q == CH_LAST) ? '0 : ch_q + 1'b1;
          cnt_next = '0;
        end else begin
          cnt_next = cnt_q + 1'b1;
        end
      end
      default: begin
        nch      = ch_q;
        cnt_next = cnt_q;
      end
    endcase
  end

  // Pick the data of the channel chosen above. The compare-and-select loop
  // only ever matches real channels, so no X can leak out of an unused
  // index code.
  always_comb begin
    din_pick = '0;
    for (int k = 0; k < NCH; k++) begin
      if (nch == SELW'(k)) begin
        din_pick = bus.din[k*WIDTH +: WIDTH];
      end
    end
  end

  // Next-state values for every register. Hold keeps the channel, counter
  // and data frozen (so din changes are ignored) but drops the strobe.
  // In the running modes the data is re-sampled every cycle, not only when
  // the channel changes, so mid-dwell updates of din reach dout one edge
  // later.
  always_comb begin
    ch_d   = ch_q;
    cnt_d  = cnt_q;
    dout_d = dout_q;
    sw_d   = 1'b0;
    case (mode)
      MODE_RESET: begin
        ch_d   = '0;
        cnt_d  = '0;
        dout_d = '0;
        sw_d   = 1'b0;
      end
      MODE_HOLD: begin
        sw_d   = 1'b0;
      end
      MODE_MANUAL, MODE_AUTO: begin
        ch_d   = nch;
        cnt_d  = cnt_next;
        dout_d = din_pick;
        sw_d   = (nch != ch_q);
      end
      default: begin
        sw_d   = 1'b0;
      end
    endcase
  end

  // State register. Reset is folded into the next-state logic above, which
  // keeps it synchronous and gives it priority over every other input.
  always_ff @(posedge clk) begin
    ch_q   <= ch_d;
    cnt_q  <= cnt_d;
    dout_q <= dout_d;
    sw_q   <= sw_d;
  end

  assign bus.dout = dout_q;
  assign bus.ch   = ch_q;
  assign bus.sw   = sw_q;

endmodule

// File: tb/tb_scan_mux.sv
// ---------------------------------------------------------------------------
// tb_scan_mux
//
// Three scan_mux instances share the control inputs:
//   inst0 : WIDTH=4, NCH=4, DWELL=4
//   inst1 : WIDTH=4, NCH=3, DWELL=4
//   inst2 : WIDTH=4, NCH=3, DWELL=1
// A behavioural model tracks where each one must be in its scan in terms of
// "start channel + elapsed running cycles / DWELL". The outputs of all three
// are compared with it on every falling edge, and directed checks pin
// specific literal values.
// ---------------------------------------------------------------------------
module tb_scan_mux;

  logic        clk = 1'b0;
  logic        rst;
  logic        auto;
  logic        hold;
  logic [1:0]  sel;
  logic [15:0] din4;
  logic [11:0] din3;

  int nVectors     = 0;
  int nMiscompares = 0;

  scan_mux_if #(.WIDTH(4), .NCH(4)) bus0 ();
  scan_mux_if #(.WIDTH(4), .NCH(3)) bus1 ();
  scan_mux_if #(.WIDTH(4), .NCH(3)) bus2 ();

  assign bus0.din  = din4;
  assign bus0.sel  = sel;
  assign bus0.auto = auto;
  assign bus0.hold = hold;
  assign bus1.din  = din3;
  assign bus1.sel  = sel;
  assign bus1.auto = auto;
  assign bus1.hold = hold;
  assign bus2.din  = din3;
  assign bus2.sel  = sel;
  assign bus2.auto = auto;
  assign bus2.hold = hold;

  scan_mux #(.WIDTH(4), .NCH(4), .DWELL(4)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  scan_mux #(.WIDTH(4), .NCH(3), .DWELL(4)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
  scan_mux #(.WIDTH(4), .NCH(3), .DWELL(1)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

  always #5 clk = ~clk;

  // Model: a scan is described by the channel it started from and how many
  // running auto cycles have elapsed since then.
  int          mN[3] = '{4, 3, 3};
  int          mD[3] = '{4, 4, 1};
  int          mCh[3];
  int          mSteps[3];
  int          mBase[3];
  logic [3:0]  mDout[3];
  logic        mSw[3];
  bit          mValid = 1'b0;

  // Advance the model on every rising edge from the inputs that the DUTs
  // sample at that same edge.
  always @(posedge clk) begin
    int         nc;
    int         ns;
    int         nb;
    logic [3:0] nd;
    for (int i = 0; i < 3; i++) begin
      nc = mCh[i];
      ns = mSteps[i];
      nb = mBase[i];
      nd = mDout[i];
      if (rst) begin
        nc = 0;
        ns = 0;
        nb = 0;
        nd = 4'h0;
        mSw[i] <= 1'b0;
      end else if (hold) begin
        mSw[i] <= 1'b0;
      end else begin
        if (!auto) begin
          if (int'(sel) < mN[i]) nc = int'(sel);
          ns = 0;
          nb = nc;
        end else begin
          ns = ns + 1;
          nc = (nb + ns / mD[i]) % mN[i];
        end
        nd = (i == 0) ? din4[nc*4 +: 4] : din3[nc*4 +: 4];
        mSw[i] <= (nc != mCh[i]);
      end
      mCh[i]    <= nc;
      mSteps[i] <= ns;
      mBase[i]  <= nb;
      mDout[i]  <= nd;
    end
    if (rst) mValid <= 1'b1;
  end

  task automatic compareInst(input int i, input logic [3:0] d,
                             input logic [1:0] c, input logic s);
    nVectors++;
    if (d !== mDout[i] || c !== 2'(mCh[i]) || s !== mSw[i]) begin
      nMiscompares++;
      $display("[TB] FAIL model_inst%0d t=%0t got dout=%h ch=%0d sw=%b, required dout=%h ch=%0d sw=%b",
               i, $time, d, c, s, mDout[i], mCh[i], mSw[i]);
    end
  endtask

  // Compare every instance against the model on each falling edge once the
  // model has seen a reset.
  always @(negedge clk) begin
    if (mValid) begin
      compareInst(0, bus0.dout, bus0.ch, bus0.sw);
      compareInst(1, bus1.dout, bus1.ch, bus1.sw);
      compareInst(2, bus2.dout, bus2.ch, bus2.sw);
    end
  end

  task automatic applyStimulus(input logic r, input logic a,
                               input logic h, input logic [1:0] s);
    rst  = r;
    auto = a;
    hold = h;
    sel  = s;
  endtask

  task automatic cycle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic checkOutput(input string name, input int inst,
                             input logic [3:0] expDout, input logic [1:0] expCh,
                             input logic expSw);
    logic [3:0] d;
    logic [1:0] c;
    logic       s;
    case (inst)
      0:       begin d = bus0.dout; c = bus0.ch; s = bus0.sw; end
      1:       begin d = bus1.dout; c = bus1.ch; s = bus1.sw; end
      default: begin d = bus2.dout; c = bus2.ch; s = bus2.sw; end
    endcase
    nVectors++;
    if (d !== expDout || c !== expCh || s !== expSw) begin
      nMiscompares++;
      $display("[TB] FAIL %s inst%0d got dout=%h ch=%0d sw=%b, required dout=%h ch=%0d sw=%b",
               name, inst, d, c, s, expDout, expCh, expSw);
    end
  endtask

  initial begin
    din4 = 16'hDCBA;
    din3 = 12'h987;
    applyStimulus(1'b1, 1'b0, 1'b0, 2'd3);

    // Reset, including a long reset with auto requested.
    cycle(2);
    checkOutput("reset", 0, 4'h0, 2'd0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 2'd1);
    cycle(10);
    checkOutput("reset_auto", 0, 4'h0, 2'd0, 1'b0);

    // Manual select and the one-cycle switch strobe.
    applyStimulus(1'b0, 1'b0, 1'b0, 2'd2);
    cycle(1);
    checkOutput("man_sel2", 0, 4'hC, 2'd2, 1'b1);
    cycle(1);
    checkOutput("man_sel2_sw_drop", 0, 4'hC, 2'd2, 1'b0);
    cycle(2);
    checkOutput("man_sel2_steady", 0, 4'hC, 2'd2, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 2'd0);
    cycle(1);
    checkOutput("man_sel0", 0, 4'hA, 2'd0, 1'b1);
    cycle(1);
    checkOutput("man_sel0_steady", 0, 4'hA, 2'd0, 1'b0);

    // Auto scan from reset, all the way around and back to channel 0.
    applyStimulus(1'b1, 1'b0, 1'b0, 2'd0);
    cycle(1);
    checkOutput("auto_pre_reset", 0, 4'h0, 2'd0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 2'd0);
    cycle(3);
    checkOutput("auto_ch0", 0, 4'hA, 2'd0, 1'b0);
    cycle(1);
    checkOutput("auto_sw4", 0, 4'hB, 2'd1, 1'b1);
    cycle(1);
    checkOutput("auto_ch1", 0, 4'hB, 2'd1, 1'b0);
    cycle(3);
    checkOutput("auto_sw8", 0, 4'hC, 2'd2, 1'b1);
    cycle(4);
    checkOutput("auto_sw12", 0, 4'hD, 2'd3, 1'b1);
    cycle(4);
    checkOutput("auto_wrap16", 0, 4'hA, 2'd0, 1'b1);
    cycle(1);
    checkOutput("auto_after_wrap", 0, 4'hA, 2'd0, 1'b0);

    // Hold two cycles into channel 1 while din for channel 1 changes.
    applyStimulus(1'b1, 1'b1, 1'b0, 2'd0);
    cycle(1);
    applyStimulus(1'b0, 1'b1, 1'b0, 2'd0);
    cycle(4);
    checkOutput("hold_enter_ch1", 0, 4'hB, 2'd1, 1'b1);
    cycle(1);
    applyStimulus(1'b0, 1'b1, 1'b1, 2'd0);
    din4 = 16'hDC5A;
    cycle(5);
    checkOutput("hold_frozen", 0, 4'hB, 2'd1, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 2'd0);
    cycle(1);
    checkOutput("hold_release1", 0, 4'h5, 2'd1, 1'b0);
    cycle(1);
    checkOutput("hold_release2", 0, 4'h5, 2'd1, 1'b0);
    cycle(1);
    checkOutput("hold_next_ch2", 0, 4'hC, 2'd2, 1'b1);

    // Reset in the middle of the dwell on channel 2.
    cycle(1);
    checkOutput("mid_ch2_cnt1", 0, 4'hC, 2'd2, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 2'd0);
    cycle(1);
    checkOutput("mid_reset", 0, 4'h0, 2'd0, 1'b0);
    din4 = 16'hDCBA;
    applyStimulus(1'b0, 1'b1, 1'b0, 2'd0);
    cycle(3);
    checkOutput("post_reset_dwell", 0, 4'hA, 2'd0, 1'b0);
    cycle(1);
    checkOutput("post_reset_sw", 0, 4'hB, 2'd1, 1'b1);
    cycle(5);
    checkOutput("again_ch2_cnt1", 0, 4'hC, 2'd2, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b1, 2'd0);
    cycle(1);
    checkOutput("reset_beats_hold", 0, 4'h0, 2'd0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 2'd0);
    cycle(1);
    checkOutput("after_reset_hold", 0, 4'hA, 2'd0, 1'b0);

    // Three-channel build: out-of-range select is ignored.
    applyStimulus(1'b1, 1'b0, 1'b0, 2'd1);
    cycle(1);
    applyStimulus(1'b0, 1'b0, 1'b0, 2'd1);
    cycle(1);
    checkOutput("nch3_sel1", 1, 4'h8, 2'd1, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 2'd3);
    cycle(1);
    checkOutput("nch3_sel3_ignored", 1, 4'h8, 2'd1, 1'b0);
    checkOutput("nch4_sel3", 0, 4'hD, 2'd3, 1'b1);
    cycle(1);
    checkOutput("nch3_sel3_steady", 1, 4'h8, 2'd1, 1'b0);

    // DWELL=1: advance every cycle with the strobe held high.
    applyStimulus(1'b1, 1'b1, 1'b0, 2'd0);
    cycle(1);
    checkOutput("dwell1_reset", 2, 4'h0, 2'd0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 2'd0);
    cycle(1);
    checkOutput("dwell1_step1", 2, 4'h8, 2'd1, 1'b1);
    cycle(1);
    checkOutput("dwell1_step2", 2, 4'h9, 2'd2, 1'b1);
    cycle(1);
    checkOutput("dwell1_wrap", 2, 4'h7, 2'd0, 1'b1);
    cycle(1);
    checkOutput("dwell1_step4", 2, 4'h8, 2'd1, 1'b1);

    // Mixed traffic, checked by the model only.
    for (int n = 0; n < 300; n++) begin
      rst  = ($urandom_range(0, 39) == 0);
      hold = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 19) == 0) auto = ~auto;
      sel  = 2'($urandom_range(0, 3));
      din4 = 16'($urandom);
      din3 = 12'($urandom);
      cycle(1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule
